mips_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle MIPS datapath: services the word read/write

---
 rtl/mips_mem_responder.sv | 142 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Word-RAM responder for the multicycle MIPS datapath: one outstanding request, fixed wait states.
// Define MIPS_MEM_ERRCHK_EN to fault misaligned or out-of-range addresses.
module mips_mem_responder #(
    parameter int    DEPTH_LOG2  = 10,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (WAIT_CYCLES > 15 || WAIT_CYCLES < 0) begin : g_bad_wait
        $error("mips_mem_responder: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept;
    logic              enter_resp;

    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;

    logic              eff_we;
    logic [31:0]       eff_addr;
    logic [31:0]       eff_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    logic              fault;

    logic [31:0]       mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the request completes on its accept edge, so it is used unlatched.
    always_comb begin
        eff_we    = lat_we;
        eff_addr  = lat_addr;
        eff_wdata = lat_wdata;
        if (state == S_IDLE) begin
            eff_we    = req_we;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
        end
    end

    assign idx = eff_addr[DEPTH_LOG2+1:2];

`ifdef MIPS_MEM_ERRCHK_EN
    assign fault = (eff_addr[1:0] != 2'b00) || (|(eff_addr[31:2] >> DEPTH_LOG2));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{eff_addr[31:DEPTH_LOG2+2], eff_addr[1:0]};
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_rdata <= (eff_we || fault) ? 32'd0 : mem[idx];
                rsp_err   <= fault;
            end
        end
    end

    // RAM has no reset; a write lands only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_we && !fault) begin
            mem[idx] <= eff_wdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: three instances with 1, 0 and 3 wait states.
module tb_mips_mem_responder;

    logic              clk;
    logic              rst_n;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [2:0]        req_we;
    logic [2:0][31:0]  req_addr;
    logic [2:0][31:0]  req_wdata;
    logic [2:0]        rsp_valid;
    logic [2:0][31:0]  rsp_rdata;
    logic [2:0]        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mips_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    mips_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request on instance i, checking latency, response fields and handshake.
    task automatic xfer(input int i, input string tag, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int lat;
        bit ready_hi;
        check_eq({tag, "_rdy_idle"}, 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
        req_addr[i]  = 32'd0;
        req_wdata[i] = 32'd0;
        lat = 0;
        ready_hi = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (rsp_valid[i]) begin
                lat = n + 1;
                break;
            end
            if (req_ready[i]) ready_hi = 1'b1;
            @(posedge clk); #1;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rsp_rdata[i], exp_rdata);
        check_eq({tag, "_err"}, 32'(rsp_err[i]), 32'(exp_err));
        check_eq({tag, "_rdy_resp"}, 32'(req_ready[i]), 32'd0);
        check_eq({tag, "_rdy_wait"}, 32'(ready_hi), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(rsp_valid[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc[4];
        logic [31:0] got[4];
        int n_acc;
        int n_rsp;
        int n_hi;

        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
            check_eq($sformatf("rst_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
            check_eq($sformatf("rst_rdata%0d", i), rsp_rdata[i], 32'd0);
            check_eq($sformatf("rst_err%0d", i), 32'(rsp_err[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read, one wait state
        xfer(0, "t2_w", 1'b1, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        xfer(0, "t2_r", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, 2);

        // Zero wait states
        xfer(1, "t3_w0w", 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 1);
        xfer(1, "t3_w0r", 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, 1);

        // Three wait states, then reset in the middle of a write's wait
        xfer(2, "t1_w", 1'b1, 32'h10, 32'h11112222, 32'd0, 1'b0, 4);
        xfer(2, "t1_r", 1'b0, 32'h10, 32'd0, 32'h11112222, 1'b0, 4);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h10;
        req_wdata[2] = 32'h99999999;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_we[2]    = 1'b0;
        @(posedge clk); #1;
        check_eq("t1_mid_ready", 32'(req_ready[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t1_rst_ready", 32'(req_ready[2]), 32'd1);
        check_eq("t1_rst_valid", 32'(rsp_valid[2]), 32'd0);
        check_eq("t1_rst_rdata", rsp_rdata[2], 32'd0);
        check_eq("t1_rst_err", 32'(rsp_err[2]), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_hi = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[2]) n_hi++;
        end
        check_eq("t1_no_rsp", 32'(n_hi), 32'd0);
        xfer(2, "t1_after", 1'b0, 32'h10, 32'd0, 32'h11112222, 1'b0, 4);

        // Continuous req_valid with four reads, junk writes offered while busy
        for (int k = 0; k < 4; k++)
            xfer(0, $sformatf("t4_w%0d", k), 1'b1, 32'(32'h80 + 4 * k),
                 32'(32'hA0A00000 + k), 32'd0, 1'b0, 2);
        n_acc = 0;
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            acc[k] = 0;
            got[k] = 32'd0;
        end
        req_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (n_acc < 4 && req_ready[0]) begin
                req_we[0]    = 1'b0;
                req_addr[0]  = 32'(32'h80 + 4 * n_acc);
                req_wdata[0] = 32'd0;
                acc[n_acc]   = c;
                n_acc++;
            end else if (n_acc < 4) begin
                req_we[0]    = 1'b1;
                req_addr[0]  = 32'h80;
                req_wdata[0] = 32'hBAD0BAD0;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
            if (rsp_valid[0]) begin
                if (n_rsp < 4) got[n_rsp] = rsp_rdata[0];
                n_rsp++;
            end
        end
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        check_eq("t4_n_acc", 32'(n_acc), 32'd4);
        check_eq("t4_n_rsp", 32'(n_rsp), 32'd4);
        for (int k = 1; k < 4; k++)
            check_eq($sformatf("t4_gap%0d", k), 32'(acc[k] - acc[k-1]), 32'd3);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("t4_data%0d", k), got[k], 32'(32'hA0A00000 + k));
        xfer(0, "t4_junk", 1'b0, 32'h80, 32'd0, 32'hA0A00000, 1'b0, 2);

        // Address wrap / error checking
        xfer(0, "t5_w0", 1'b1, 32'h0, 32'h12345678, 32'd0, 1'b0, 2);
`ifdef MIPS_MEM_ERRCHK_EN
        xfer(0, "t6_w41", 1'b1, 32'h41, 32'h00000077, 32'd0, 1'b1, 2);
        xfer(0, "t6_w1000", 1'b1, 32'h1000, 32'h00000055, 32'd0, 1'b1, 2);
        xfer(0, "t6_r40", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, 2);
        xfer(0, "t6_r0", 1'b0, 32'h0, 32'd0, 32'h12345678, 1'b0, 2);
`else
        xfer(0, "t5_w1000", 1'b1, 32'h1000, 32'h00000055, 32'd0, 1'b0, 2);
        xfer(0, "t5_r0", 1'b0, 32'h0, 32'd0, 32'h00000055, 1'b0, 2);
        xfer(0, "t5_r41", 1'b0, 32'h41, 32'd0, 32'hDEADBEEF, 1'b0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
